// File: rtl/pipe_int_mul_issuer_if.sv
// Host operand/result channels plus multiplier operand/commit handshake for pipe_int_mul_issuer.
// slave = issuer side, master = host/multiplier side.
interface pipe_int_mul_issuer_if;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_val_op;
    logic        mul_oprand_rdy;
    logic        mul_commit;
    logic [63:0] mul_longP;
    logic        rsp_val;
    logic        rsp_rdy;
    logic [63:0] rsp_data;
    logic        err;

    modport slave (
        input  req_val, req_a, req_b, mul_oprand_rdy, mul_commit, mul_longP, rsp_rdy,
        output req_rdy, mul_a, mul_b, mul_val_op, rsp_val, rsp_data, err
    );

    modport master (
        output req_val, req_a, req_b, mul_oprand_rdy, mul_commit, mul_longP, rsp_rdy,
        input  req_rdy, mul_a, mul_b, mul_val_op, rsp_val, rsp_data, err
    );
endinterface

// File: rtl/pipe_int_mul_issuer.sv
// Operand issuer / in-order result collector for a pipelined 32x32->64 multiplier.
// Latency: multiplier latency + 2 cycles request->response (commit visible on rsp the cycle after).
// Backpressure: credits cap held+in-flight+queued at DEPTH so commits never drop; PIPE_INT_MUL_ISSUER_CHK_EN adds sticky err.
module pipe_int_mul_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_int_mul_issuer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic          rst_done_q, rst_done_d;
    logic          hold_v_q, hold_v_d;
    logic [31:0]   hold_a_q, hold_a_d;
    logic [31:0]   hold_b_q, hold_b_d;
    logic [CW-1:0] cred_q, cred_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [63:0]   mem_q [DEPTH];

    logic issue_fire, rsp_val, pop, req_rdy, accept, push;

    assign issue_fire = hold_v_q & bus.mul_oprand_rdy;
    assign rsp_val    = (cnt_q != '0);
    assign pop        = rsp_val & bus.rsp_rdy;
    assign req_rdy    = rst_done_q & (~hold_v_q | issue_fire) & ((cred_q < CW'(DEPTH)) | pop);
    assign accept     = bus.req_val & req_rdy;

`ifdef PIPE_INT_MUL_ISSUER_CHK_EN
    logic err_q, err_d;
    logic bad_commit;
    // A commit with nothing in flight, or into a full FIFO that is not draining, is dropped.
    assign bad_commit = bus.mul_commit & ((infl_q == '0) | ((cnt_q == CW'(DEPTH)) & ~pop));
    assign push       = bus.mul_commit & ~bad_commit;
    assign err_d      = err_q | bad_commit;
    assign bus.err    = err_q;
`else
    assign push    = bus.mul_commit;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        rst_done_d = 1'b1;
        hold_v_d   = hold_v_q;
        hold_a_d   = hold_a_q;
        hold_b_d   = hold_b_q;
        cred_d     = cred_q;
        infl_d     = infl_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (accept) begin
            hold_v_d = 1'b1;
            hold_a_d = bus.req_a;
            hold_b_d = bus.req_b;
        end else if (issue_fire) begin
            hold_v_d = 1'b0;
        end

        if (accept && !pop)
            cred_d = cred_q + CW'(1);
        else if (!accept && pop && cred_q != '0)
            cred_d = cred_q - CW'(1);

        // Saturate at zero so an unchecked stray commit cannot wrap the count.
        if (issue_fire && !(push && infl_q != '0))
            infl_d = infl_q + CW'(1);
        else if (!issue_fire && push && infl_q != '0)
            infl_d = infl_q - CW'(1);

        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);

        if (push)
            wptr_d = wptr_q + AW'(1);
        if (pop)
            rptr_d = rptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done_q <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
            cred_q     <= '0;
            infl_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
`ifdef PIPE_INT_MUL_ISSUER_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            rst_done_q <= rst_done_d;
            hold_v_q   <= hold_v_d;
            hold_a_q   <= hold_a_d;
            hold_b_q   <= hold_b_d;
            cred_q     <= cred_d;
            infl_q     <= infl_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
`ifdef PIPE_INT_MUL_ISSUER_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Storage needs no reset: the read port is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= bus.mul_longP;
    end

    assign bus.req_rdy    = req_rdy;
    assign bus.mul_val_op = hold_v_q;
    assign bus.mul_a      = hold_a_q;
    assign bus.mul_b      = hold_b_q;
    assign bus.rsp_val    = rsp_val;
    assign bus.rsp_data   = rsp_val ? mem_q[rptr_q] : 64'h0;
endmodule
